param_sync_fifo: RTL
====================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries, a power of two >=2.
REQ-003 SHALL have parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-2, almost-full level in entries.
REQ-005 SHALL have parameter AE_THRESH, default 2, almost-empty level in entries.
REQ-006 SHALL have ports, in this order:
- clk  input  1  single clock, rising edge; one clock only.
- res_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous empty request.
- wr_en  input  1  write request.
- wdata  input  WIDTH  write data.
- rd_en  input  1  read request.
- rdata  output  WIDTH  read data.
- full  output  1  no free entry.
- empty  output  1  no stored entry.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  stored entries, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.
- err_clr  input  1  clears overflow and underflow.

Function
REQ-007 SHALL accept a write iff wr_en=1, full=0 and flush=0; the accepted word is stored at the write address, which then advances.
REQ-008 SHALL accept a read iff rd_en=1, empty=0 and flush=0; the read address then advances.
REQ-009 SHALL keep write and read pointers of $clog2(DEPTH)+1 bits; the low bits address memory and the MSB is a wrap bit toggling on every pass through DEPTH-1 -> 0.
REQ-010 SHALL drive empty=1 when the pointers are fully equal, and full=1 when the addresses are equal and the wrap bits differ.
REQ-011 SHALL register count and update it one cycle after the edge: +1 on write only, -1 on read only, unchanged when both are accepted in the same cycle, and never outside 0..DEPTH.
REQ-012 SHALL derive full, empty, almost_full and almost_empty from the registered state, valid in the same cycle as count.
REQ-013 With FWFT=0, SHALL register rdata with the head word on the edge that accepts a read, visible the next cycle; otherwise rdata holds.
REQ-014 With FWFT=1, SHALL drive rdata from the head entry whenever empty=0 and drive 0 when empty=1; an accepted read exposes the next entry the following cycle.
REQ-015 SHALL refuse writes when full, even if a read is requested in the same cycle.
REQ-016 SHALL refuse reads when empty, even if a write is requested in the same cycle; there is no write-to-read bypass.
REQ-017 SHALL set overflow on any edge where wr_en=1 and full=1, and set underflow on any edge where rd_en=1 and empty=1.
REQ-018 When err_clr=1, SHALL clear overflow and underflow; a set event in the same cycle wins over the clear.
REQ-019 When flush=1, SHALL on that edge zero both pointers and count, ignore wr_en and rd_en, and leave memory, rdata and the sticky flags unchanged.
REQ-020 SHALL never modify pointers, count or memory on a refused request.

Reset
REQ-021 On res_n=0, SHALL immediately, without waiting for a clock edge, force pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (for AF_THRESH>0), overflow=0, underflow=0 and rdata=0.
REQ-022 SHALL not reset memory contents; reset assertion mid-operation discards all stored data.
REQ-023 SHALL release from reset cleanly: the first rising edge with res_n=1 may accept a write.

Structure
REQ-024 SHALL take a shared package fifo_pkg containing the pointer-width helper function and the default threshold constants.
REQ-025 SHALL place storage in sub-module fifo_mem: DEPTH x WIDTH, one synchronous write port and one asynchronous read port, no reset; the pointer, flag and count logic stays in param_sync_fifo.

Verification
REQ-026 Fill with WIDTH=8, DEPTH=16: write 0x00..0x0F back to back -> full=1, count=16 and almost_full=1 from count 14; a 17th write -> overflow=1 and count stays 16.
REQ-027 Drain with FWFT=0: from full, read 16 times -> rdata 0x00..0x0F, each one cycle after its read; empty=1 afterwards; a further read -> underflow=1 and rdata holds 0x0F.
REQ-028 Simultaneous access at count=5: wr_en=rd_en=1 for 20 cycles -> count stays 5 and the data order is preserved across pointer wrap.
REQ-029 FWFT=1: a single write of 0xA5 into an empty FIFO -> the next cycle shows empty=0 and rdata=0xA5 with no read issued; one read -> empty=1 and rdata=0.
REQ-030 flush at count=9 with wr_en=1 -> the next cycle shows count=0 and empty=1, the write is not stored, and overflow/underflow are unchanged.
REQ-031 Asynchronous reset mid-burst: drop res_n between clock edges -> all outputs reach their reset values before the next edge; an err_clr pulse combined with a simultaneous overflow event leaves overflow=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and pointer-width helper for the sync FIFO
package fifo_pkg;

  localparam int AE_THRESH_DEF = 2;
  // almost_full defaults to this many entries below DEPTH
  localparam int AF_MARGIN_DEF = 2;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]           rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - single-clock FIFO with registered or fall-through read
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - AF_MARGIN_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] head_word;

  // MSB of each pointer is the wrap bit: equal addresses with differing wrap means full
  assign empty        = (wptr_q == rptr_q);
  assign full         = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // a new error event takes priority over a clear in the same cycle
      if (wr_en && full)       ovf_d = 1'b1;
      else if (err_clr)        ovf_d = 1'b0;
      if (rd_en && empty)      udf_d = 1'b1;
      else if (err_clr)        udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (head_word)
  );

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)      rdata_q <= '0;
        else if (rd_acc) rdata_q <= head_word;
      end
      assign rdata = rdata_q;
    end else begin : g_fwft_read
      assign rdata = empty ? '0 : head_word;
    end
  endgenerate

endmodule
